// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared constants for the pipeline control-register chain.
//   - Field offsets of the execute/memory control bundle
//     (RegWrite, ResultSrc[1:0], MemWrite).
//   - Upper bound on the number of cascaded stages.
//   - Default reset and bubble bundle values.
// No ports (package).
package pipe_ctrl_pkg;

   localparam int unsigned CTRL_REGWRITE_BIT  = 0;
   localparam int unsigned CTRL_RESULTSRC_LSB = 1;
   localparam int unsigned CTRL_RESULTSRC_W   = 2;
   localparam int unsigned CTRL_MEMWRITE_BIT  = 3;
   localparam int unsigned EM_CTRL_W          = 4;

   localparam int unsigned MAX_STAGES = 8;

   localparam logic [EM_CTRL_W-1:0] CTRL_RESET_VALUE  = '0;
   localparam logic [EM_CTRL_W-1:0] CTRL_BUBBLE_VALUE = '0;

   // Field view of the execute/memory bundle, MSB first.
   typedef struct packed {
      logic       mem_write;
      logic [1:0] result_src;
      logic       reg_write;
   } em_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_chain_if.sv
// pipe_ctrl_chain_if: control-bundle bus between the upstream pipeline logic
// and the control-register chain.
//   ctrl_i/valid_i   bundle and valid entering stage 0
//   stall/flush      per-stage hold and clear requests (bit k = stage k)
//   ctrl_o/valid_o   bundle and valid of the last stage
//   ctrl_all_o       every stage bundle, stage k at [k*WIDTH +: WIDTH]
//   valid_all_o      every stage valid
//   stall_o          effective stall of stage 0
// Modports: master = upstream side, slave = the chain.
interface pipe_ctrl_chain_if
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH  = EM_CTRL_W,
   parameter int unsigned STAGES = 1
);

   logic [WIDTH-1:0]        ctrl_i;
   logic                    valid_i;
   logic [STAGES-1:0]       stall;
   logic [STAGES-1:0]       flush;
   logic [WIDTH-1:0]        ctrl_o;
   logic                    valid_o;
   logic [STAGES*WIDTH-1:0] ctrl_all_o;
   logic [STAGES-1:0]       valid_all_o;
   logic                    stall_o;

   modport master (
      output ctrl_i, valid_i, stall, flush,
      input  ctrl_o, valid_o, ctrl_all_o, valid_all_o, stall_o
   );

   modport slave (
      input  ctrl_i, valid_i, stall, flush,
      output ctrl_o, valid_o, ctrl_all_o, valid_all_o, stall_o
   );

endinterface

// File: rtl/flopenrc.sv
// flopenrc: WIDTH-bit register with asynchronous active-low reset to
// RESET_VALUE, synchronous clear to CLEAR_VALUE and a load enable.
// Clear has priority over enable.
//   clk    clock, rising edge
//   n_rst  asynchronous reset, active low
//   en     load d on the next edge
//   clr    load CLEAR_VALUE on the next edge (overrides en)
//   d      next value
//   q      registered value
module flopenrc #(
   parameter int unsigned      WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         q <= RESET_VALUE;
      end else if (clr) begin
         q <= CLEAR_VALUE;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain: cascade of STAGES stallable/flushable control registers
// carrying a pipeline control bundle plus a valid bit.
//   clk                 clock, rising edge
//   n_rst               asynchronous reset, active low
//   bus (slave)         ctrl_i, valid_i, stall, flush in;
//                       ctrl_o, valid_o, ctrl_all_o, valid_all_o, stall_o out
//   perf_clr            synchronous clear of the performance counters
//   stall_cnt_o         cycles with the last stage held
//   flush_cnt_o         cycles in which a valid stage was flushed
//   bubble_cnt_o        cycles in which a bubble was inserted below a hold
// Build option: PIPE_CTRL_CHAIN_PERF_EN enables the saturating counters;
// without it the counter outputs are tied to zero and perf_clr is ignored.
// STAGES must be 1..MAX_STAGES.
module pipe_ctrl_chain
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned      WIDTH        = EM_CTRL_W,
   parameter int unsigned      STAGES       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE  = WIDTH'(CTRL_RESET_VALUE),
   parameter logic [WIDTH-1:0] BUBBLE_VALUE = WIDTH'(CTRL_BUBBLE_VALUE),
   parameter int unsigned      CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 n_rst,
   pipe_ctrl_chain_if.slave     bus,
   input  logic                 perf_clr,
   output logic [CNT_WIDTH-1:0] stall_cnt_o,
   output logic [CNT_WIDTH-1:0] flush_cnt_o,
   output logic [CNT_WIDTH-1:0] bubble_cnt_o
);

   logic [STAGES-1:0] hold;
   logic [STAGES-1:0] valid_q;
   logic [STAGES-1:0] bubble;
   logic [WIDTH-1:0]  ctrl_q [STAGES];

   // A stage is held when it or any stage below it stalls.
   always_comb begin
      hold = '0;
      for (int k = 0; k < STAGES; k++) begin
         hold[k] = |(bus.stall >> k);
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] d_ctrl;
      logic             d_valid;

      if (k == 0) begin : g_first
         assign d_valid   = bus.valid_i;
         assign d_ctrl    = bus.valid_i ? bus.ctrl_i : BUBBLE_VALUE;
         assign bubble[k] = 1'b0;
      end else begin : g_next
         // Upstream neighbour held while this stage moves on: fill with a bubble.
         assign d_valid   = valid_q[k-1] & ~hold[k-1];
         assign d_ctrl    = d_valid ? ctrl_q[k-1] : BUBBLE_VALUE;
         assign bubble[k] = hold[k-1] & ~hold[k] & ~bus.flush[k];
      end

      flopenrc #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE),
         .CLEAR_VALUE (BUBBLE_VALUE)
      ) u_ctrl (
         .clk   (clk),
         .n_rst (n_rst),
         .en    (~hold[k]),
         .clr   (bus.flush[k]),
         .d     (d_ctrl),
         .q     (ctrl_q[k])
      );

      flopenrc #(
         .WIDTH       (1),
         .RESET_VALUE (1'b0),
         .CLEAR_VALUE (1'b0)
      ) u_valid (
         .clk   (clk),
         .n_rst (n_rst),
         .en    (~hold[k]),
         .clr   (bus.flush[k]),
         .d     (d_valid),
         .q     (valid_q[k:k])
      );

      assign bus.ctrl_all_o[k*WIDTH +: WIDTH] = ctrl_q[k];
   end

   assign bus.valid_all_o = valid_q;
   assign bus.ctrl_o      = ctrl_q[STAGES-1];
   assign bus.valid_o     = valid_q[STAGES-1];
   assign bus.stall_o     = hold[0];

`ifdef PIPE_CTRL_CHAIN_PERF_EN
   logic                 stall_evt;
   logic                 flush_evt;
   logic                 bubble_evt;
   logic [CNT_WIDTH-1:0] stall_cnt;
   logic [CNT_WIDTH-1:0] flush_cnt;
   logic [CNT_WIDTH-1:0] bubble_cnt;

   assign stall_evt  = hold[STAGES-1];
   assign flush_evt  = |(bus.flush & valid_q);
   assign bubble_evt = |bubble;

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         bubble_cnt <= '0;
      end else if (perf_clr) begin
         stall_cnt  <= '0;
         flush_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stall_evt && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (flush_evt && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
         if (bubble_evt && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
         end
      end
   end

   assign stall_cnt_o  = stall_cnt;
   assign flush_cnt_o  = flush_cnt;
   assign bubble_cnt_o = bubble_cnt;
`else
   logic unused_perf;
   assign unused_perf  = perf_clr | (|bubble);
   assign stall_cnt_o  = '0;
   assign flush_cnt_o  = '0;
   assign bubble_cnt_o = '0;
`endif

endmodule

// File: doc/pipe_ctrl_chain.md
# pipe_ctrl_chain

Parametrised chain of pipeline control registers carrying a stage's control bundle (RegWrite, ResultSrc, MemWrite, …) through one or more pipeline boundaries. Each stage supports stall (hold), flush (bubble insert), a valid bit, upstream stall propagation and automatic bubble insertion below a stalled stage. It replaces the fixed-width, non-stallable per-boundary control registers in the pipelined core. Optional saturating performance counters are compiled in by macro.

## Interface
- WIDTH, 4: control bundle width in bits.
- STAGES, 1: number of cascaded register stages (1..8).
- RESET_VALUE, 0: bundle value held in every stage after reset.
- BUBBLE_VALUE, 0: bundle value loaded on flush or bubble insertion.
- CNT_WIDTH, 16: performance counter width.

- clk  in  1  clock, rising edge.
- n_rst  in  1  reset, asynchronous, active-low.
- ctrl_i  in  WIDTH  control bundle entering stage 0.
- valid_i  in  1  ctrl_i carries a real instruction.
- stall  in  STAGES  per-stage hold request; bit k = stage k.
- flush  in  STAGES  per-stage clear request; bit k = stage k.
- ctrl_o  out  WIDTH  output of stage STAGES-1.
- valid_o  out  1  valid of stage STAGES-1.
- ctrl_all_o  out  STAGES*WIDTH  all stage bundles, stage k at [k*WIDTH +: WIDTH].
- valid_all_o  out  STAGES  all stage valids.
- stall_o  out  1  effective stall of stage 0 (upstream must hold its fetch/decode).
- perf_clr  in  1  synchronous clear of counters.
- stall_cnt_o, flush_cnt_o, bubble_cnt_o  out  CNT_WIDTH  performance counters.

## Operation
- Effective stall: hold[k] = OR of stall[k..STAGES-1]; a stall propagates upstream, never downstream.
- Per stage k, priority on each rising edge: flush[k] > hold[k] > load.
  - flush[k]: bundle <= BUBBLE_VALUE, valid <= 0 (even if hold[k]).
  - hold[k] (no flush): bundle and valid unchanged.
  - load: stage 0 takes ctrl_i/valid_i; stage k>0 takes stage k-1, except when hold[k-1]=1, then bundle <= BUBBLE_VALUE, valid <= 0 (bubble inserted below the hold boundary).
- valid=0 stages always carry BUBBLE_VALUE on load; stage 0 loads BUBBLE_VALUE when valid_i=0 regardless of ctrl_i.
- stall_o = hold[0].
- Counters (macro enabled), each saturates at all-ones, never wraps:
  - stall_cnt_o +1 per cycle with hold[STAGES-1]=1.
  - flush_cnt_o +1 per cycle with flush[k]=1 and valid[k]=1 for any k (one count per cycle max).
  - bubble_cnt_o +1 per cycle with an automatic bubble inserted at any stage.
  - perf_clr zeroes all three next edge; perf_clr wins over increment.

## Timing
- Reset (asynchronous assert, n_rst low): every bundle = RESET_VALUE, every valid = 0, counters = 0; held until n_rst high. Reset mid-stall/flush discards all in-flight content.
- Latency ctrl_i -> ctrl_o: STAGES cycles with no stall/flush.
- stall/flush are sampled at the edge; effect visible on outputs the cycle after. stall_o is combinational from stall.
- Throughput one bundle per cycle when no stall.

## Configuration
- PIPE_CTRL_CHAIN_PERF_EN defined: counters implemented as above.
- Not defined: counter logic absent, stall_cnt_o/flush_cnt_o/bubble_cnt_o tied to 0, perf_clr ignored; datapath behaviour identical.

## Structure
- Package pipe_ctrl_pkg: field offsets for the execute/memory bundle (CTRL_REGWRITE_BIT=0, CTRL_RESULTSRC_LSB=1, CTRL_RESULTSRC_W=2, CTRL_MEMWRITE_BIT=3, EM_CTRL_W=4), MAX_STAGES=8, default BUBBLE/RESET constants.
- Sub-module flopenrc: WIDTH-bit register with async active-low reset to RESET_VALUE, synchronous clear to a clear value, and enable; instantiated twice per stage (bundle, valid) via generate loop.

## Test plan
- Reset: drive n_rst=0 mid-run with WIDTH=4, RESET_VALUE=4'h0 -> ctrl_o=0, valid_o=0 immediately, counters 0.
- Streaming STAGES=2: ctrl_i=4'h1,4'h5,4'h9 valid -> ctrl_o shows 1,5,9 on cycles 2,3,4 after launch, valid_o=1.
- Stall stage 1 for 2 cycles with STAGES=2 -> stall_o=1, ctrl_o and stage 0 hold; after release sequence resumes with no loss or duplication; stall_cnt_o=2.
- Stall stage 0 only, STAGES=2, stage 0 holds 4'h5 -> stage 1 receives BUBBLE_VALUE with valid=0 next cycle; bubble_cnt_o increments by 1 per stalled cycle.
- Flush and stall same stage same cycle, stage holding valid 4'h9 -> stage becomes BUBBLE_VALUE, valid=0; flush_cnt_o +1.
- Counter saturation, CNT_WIDTH=4: 20 stall cycles -> stall_cnt_o=4'hF; perf_clr together with stall -> 0 next cycle.
